// File: rtl/wait_state_memory.sv
// wait_state_memory: single-port RAM behind a req/ready handshake with programmable wait states.
// Latency: commit on the (WAIT_CYCLES+1)th edge after accept; ready pulses for the cycle after commit.
// Backpressure: req is ignored while busy; a new req is accepted in IDLE or during the DONE cycle.
// Optional MEM_RANGE_CHECK_EN: out-of-range addresses skip the array, read as 0 and raise err.
module wait_state_memory #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 13,
    parameter int DEPTH       = 8192,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] inData,
    output logic [DATA_W-1:0] outData,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [3:0]        waitCnt;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] dataQ;
    logic              weQ;
    logic              accept;
    logic              commit;
    logic              inRange;
    logic [IDX_W-1:0]  memIdx;

    logic [DATA_W-1:0] mem [DEPTH];

    assign accept = req && ((state == IDLE) || (state == DONE));
    assign commit = (state == WAIT) && (waitCnt == 4'd0);
    assign memIdx = IDX_W'(addrQ);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (req) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = req ? WAIT : IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state flops, so they stay glitch-free and registered
    always_comb begin
        busy  = (state == WAIT);
        ready = (state == DONE);
    end

    // Request capture and wait counter; inputs are frozen from accept until commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrQ   <= '0;
            dataQ   <= '0;
            weQ     <= 1'b0;
            waitCnt <= 4'd0;
        end else if (accept) begin
            addrQ   <= address;
            dataQ   <= inData;
            weQ     <= writeEn;
            waitCnt <= 4'(WAIT_CYCLES);
        end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
            waitCnt <= waitCnt - 4'd1;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic errQ;

    assign inRange = ({1'b0, addrQ} < DEPTH_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errQ <= 1'b0;
        end else begin
            errQ <= commit && !inRange;
        end
    end

    assign err = errQ;
`else
    assign inRange = 1'b1;
    assign err     = 1'b0;
`endif

    // Array has no reset; a write in flight when rst drops never reaches the commit edge
    always_ff @(posedge clk) begin
        if (commit && weQ && inRange) begin
            mem[memIdx] <= dataQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outData <= '0;
        end else if (commit && !weQ) begin
            outData <= inRange ? mem[memIdx] : '0;
        end
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory: three instances (default, zero wait states, DEPTH=1024)
// driven by directed steps followed by random traffic against an array-based reference model.
module tb_wait_state_memory;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [2:0]       writeEn;
    logic [2:0][12:0] address;
    logic [2:0][7:0]  inData;
    logic [2:0][7:0]  outData;
    logic [2:0]       ready;
    logic [2:0]       busy;
    logic [2:0]       err;

    int nCmp  = 0;
    int nFail = 0;
    int cyc   = 0;

    bit   [7:0] mdl [3][8192];
    logic [7:0] lastRead [3];
    int         wAddr [3][64];
    int         wCnt [3];
    int         prevReadyCyc [3];

    logic [7:0] rd;
    int         sum;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wait_state_memory #(.DATA_W(8), .ADDR_W(13), .DEPTH(8192), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .writeEn(writeEn[0]), .address(address[0]),
        .inData(inData[0]), .outData(outData[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0])
    );

    wait_state_memory #(.DATA_W(8), .ADDR_W(13), .DEPTH(8192), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .writeEn(writeEn[1]), .address(address[1]),
        .inData(inData[1]), .outData(outData[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1])
    );

    wait_state_memory #(.DATA_W(8), .ADDR_W(13), .DEPTH(1024), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req[2]), .writeEn(writeEn[2]), .address(address[2]),
        .inData(inData[2]), .outData(outData[2]), .ready(ready[2]), .busy(busy[2]), .err(err[2])
    );

    function automatic int depthOf(input int k);
        return (k == 2) ? 1024 : 8192;
    endfunction

    function automatic int waitOf(input int k);
        return (k == 1) ? 0 : 2;
    endfunction

    // Word actually touched by an address, or -1 when the access must leave the array alone
    function automatic int effIdx(input int k, input int a);
`ifdef MEM_RANGE_CHECK_EN
        if (a >= depthOf(k)) return -1;
`endif
        return a % depthOf(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One access on instance k; holdNext keeps req high so the next call chains back-to-back
    task automatic access(input int k, input bit we, input int a, input logic [7:0] d,
                          input bit chained, input bit holdNext, output logic [7:0] rdOut);
        int         lat;
        int         busyCnt;
        int         e;
        logic [7:0] expRd;
        bit         expErr;
        req[k]     = 1'b1;
        writeEn[k] = we;
        address[k] = 13'(a);
        inData[k]  = d;
        @(posedge clk); #1;
        req[k]     = holdNext;
        writeEn[k] = 1'($urandom);
        address[k] = 13'($urandom);
        inData[k]  = 8'($urandom);
        lat = 0;
        busyCnt = 0;
        while (ready[k] !== 1'b1 && lat < 40) begin
            if (busy[k] === 1'b1) busyCnt++;
            @(posedge clk); #1;
            lat++;
        end
        e = effIdx(k, a);
        expErr = (e < 0);
        if (we) begin
            if (e >= 0) mdl[k][e] = d;
            if (wCnt[k] < 64) begin
                wAddr[k][wCnt[k]] = a;
                wCnt[k]++;
            end
            expRd = lastRead[k];
        end else begin
            expRd = (e < 0) ? 8'h00 : mdl[k][e];
            lastRead[k] = expRd;
        end
        rdOut = outData[k];
        check($sformatf("latency k%0d a%0d", k, a), lat, waitOf(k) + 1);
        check($sformatf("busyCycles k%0d", k), busyCnt, waitOf(k) + 1);
        check($sformatf("busyAtReady k%0d", k), 32'(busy[k]), 32'd0);
        check($sformatf("outData k%0d a%0d we%0d", k, a, we), 32'(outData[k]), 32'(expRd));
        check($sformatf("err k%0d a%0d", k, a), 32'(err[k]), 32'(expErr));
        if (chained) check($sformatf("spacing k%0d", k), cyc - prevReadyCyc[k], waitOf(k) + 2);
        prevReadyCyc[k] = cyc;
        req[k] = 1'b0;
        if (!holdNext) begin
            @(posedge clk); #1;
            check($sformatf("readyClear k%0d", k), 32'(ready[k]), 32'd0);
            check($sformatf("errClear k%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("idleBusy k%0d", k), 32'(busy[k]), 32'd0);
        end
    endtask

    initial begin
        rst     = 1'b0;
        req     = '0;
        writeEn = '0;
        address = '0;
        inData  = '0;
        for (int k = 0; k < 3; k++) begin
            lastRead[k] = 8'h00;
            wCnt[k] = 0;
            prevReadyCyc[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstOut k%0d", k), 32'(outData[k]), 32'd0);
            check($sformatf("rstReady k%0d", k), 32'(ready[k]), 32'd0);
            check($sformatf("rstBusy k%0d", k), 32'(busy[k]), 32'd0);
            check($sformatf("rstErr k%0d", k), 32'(err[k]), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, two wait states
        access(0, 1'b1, 1000, 8'h1A, 1'b0, 1'b0, rd);
        access(0, 1'b0, 1000, 8'h00, 1'b0, 1'b0, rd);

        // Ten words of 0x1A, read back with req held high
        for (int i = 1; i < 10; i++) access(0, 1'b1, 1000 + i, 8'h1A, 1'b0, 1'b0, rd);
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            access(0, 1'b0, 1000 + i, 8'h00, i > 0, i < 9, rd);
            sum += int'(rd);
        end
        check("burstSum", sum, 260);

        // Zero wait states, back-to-back write/read
        access(1, 1'b1, 7, 8'h55, 1'b0, 1'b1, rd);
        access(1, 1'b0, 7, 8'h00, 1'b1, 1'b0, rd);

        // Reset during the wait states of a write drops that write
        access(0, 1'b1, 20, 8'h3C, 1'b0, 1'b0, rd);
        req[0] = 1'b1;
        writeEn[0] = 1'b1;
        address[0] = 13'd20;
        inData[0] = 8'hFF;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("busyBeforeRst", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midRstOut k%0d", k), 32'(outData[k]), 32'd0);
            check($sformatf("midRstReady k%0d", k), 32'(ready[k]), 32'd0);
            check($sformatf("midRstBusy k%0d", k), 32'(busy[k]), 32'd0);
            lastRead[k] = 8'h00;
        end
        @(posedge clk); #1;
        check("busyInRst", 32'(busy[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("busyAfterRst", 32'(busy[0]), 32'd0);
        check("readyAfterRst", 32'(ready[0]), 32'd0);
        access(0, 1'b0, 20, 8'h00, 1'b0, 1'b0, rd);

        // Addresses beyond DEPTH on the 1024-word instance
        access(2, 1'b1, 476, 8'h5A, 1'b0, 1'b0, rd);
        access(2, 1'b0, 476, 8'h00, 1'b0, 1'b0, rd);
        access(2, 1'b1, 1500, 8'hC3, 1'b0, 1'b0, rd);
        access(2, 1'b0, 476, 8'h00, 1'b0, 1'b0, rd);
        access(2, 1'b0, 1500, 8'h00, 1'b0, 1'b0, rd);

        // Random traffic, mixing isolated and chained accesses
        for (int k = 0; k < 3; k++) begin
            bit prevHold;
            prevHold = 1'b0;
            for (int i = 0; i < 30; i++) begin
                bit hold;
                bit we;
                int a;
                hold = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
                we = (wCnt[k] == 0) || ($urandom_range(0, 1) == 1);
                if (we) a = (k == 2) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 8191));
                else    a = wAddr[k][$urandom_range(0, wCnt[k] - 1)];
                access(k, we, a, 8'($urandom), prevHold, hold, rd);
                prevHold = hold;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/wait_state_memory.md
# wait_state_memory

Parametrised single-port data/instruction memory with a request/ready handshake and programmable wait states, replacing the zero-latency combinational-read memory of the multi-cycle CPU. The CPU control unit issues one access at a time and stalls until `ready` pulses. Width, depth and wait-state count are parameters, so the same block serves the 8-bit CPU and wider derivatives. Reads are registered, giving an inferable synchronous RAM.

## Interface
- `DATA_W`, default 8: data word width in bits.
- `ADDR_W`, default 13: address width in bits.
- `DEPTH`, default 8192: number of implemented words, 1..2^ADDR_W.
- `WAIT_CYCLES`, default 2: wait states inserted per access, 0..15.

- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  1: access request, sampled on `clk` when the block can accept.
- `writeEn`  in  1: 1 = write, 0 = read; sampled with `req`.
- `address`  in  ADDR_W: word address; sampled with `req`.
- `inData`  in  DATA_W: write data; sampled with `req`.
- `outData`  out  DATA_W: registered read data.
- `ready`  out  1: one-cycle completion pulse.
- `busy`  out  1: high while an access is in wait states.
- `err`  out  1: out-of-range flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Accept condition: `req` = 1 at a rising edge while the state is IDLE or DONE.
  - On accept, latch `address`, `writeEn` and `inData`.
  - Load the wait counter with WAIT_CYCLES and enter WAIT.
- `req` is ignored in WAIT; latched values are immune to input changes.
- WAIT with counter > 0: decrement the counter each edge.
- WAIT with counter = 0, at that edge:
  - Perform the access.
  - Read: `outData` <= mem[latched address].
  - Write: mem[latched address] <= latched data; `outData` unchanged.
  - Set `ready` = 1 and enter DONE.
- DONE lasts one cycle; `ready` clears at the next edge.
  - Next state is WAIT if a new request is accepted (back-to-back), else IDLE.
- `busy` = (state == WAIT).
- `outData` holds the last read value until the next read completes.
- Memory contents are not cleared by reset and are undefined unless written.
- Reset values: `outData` = 0, `ready` = 0, `busy` = 0, `err` = 0, counter = 0.
- Reset asserted mid-access: the FSM returns to IDLE immediately. A write not yet committed, meaning before the counter-0 edge, is dropped.

## Timing
- Accept at edge E0; accesses commit at edge E(WAIT_CYCLES+1); `ready` is high for the cycle after that edge.
- WAIT_CYCLES = 0: commit at E1.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles; DONE overlaps the next accept.
- `busy` is high from after E0 until after E(WAIT_CYCLES+1).
- Outputs are all registered; there are no combinational input-to-output paths.

## Configuration
- Macro `MEM_RANGE_CHECK_EN`.
- Defined:
  - A latched address >= DEPTH does not touch the array.
  - For reads, `outData` <= 0.
  - `err` = 1 for the same cycle as `ready`, then clears with it.
  - `ready` still pulses normally, so the CPU never hangs.
- Not defined:
  - No compare logic is built and `err` is tied to 0.
  - Out-of-range addresses are a user error; the array index uses the low bits of `address` only.

## Test plan
- Parameters DATA_W=8, ADDR_W=13, DEPTH=8192, WAIT_CYCLES=2 unless stated.
- Write 0x1A to 1000, then read 1000 -> `ready` pulses after the 3rd edge following each accept; `outData` = 0x1A; `busy` is high for exactly 3 cycles per access.
- Write 0x1A to 1000..1009, then read all ten back-to-back with `req` held high -> each `ready` is 4 cycles apart; summing the results gives 260 (0x104).
- WAIT_CYCLES=0: write 0x55 to 7, then read 7 -> `ready` one cycle after accept; `outData` = 0x55; accesses occur every 2 cycles.
- Pull `rst` low during WAIT of a write of 0xFF to 20, where 20 previously held 0x3C -> after release, read 20 returns 0x3C; `outData`, `ready` and `busy` were all 0 during reset.
- Toggle `address` and `inData` during WAIT -> the access uses the values latched at accept.
- With `MEM_RANGE_CHECK_EN` and DEPTH=1024: read 1500 -> `ready` = 1, `err` = 1, `outData` = 0. Write to 1500 followed by read 476 -> 476 is unchanged. Without the macro, `err` stays 0 throughout.
